// File: rtl/dpram_fifo_ctrl_pkg.sv
// dpram_fifo_ctrl_pkg: size derivations shared by every dpram user
package dpram_fifo_ctrl_pkg;
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
  // Room for a full RAM plus the two output-stage words.
  function automatic int level_width(input int aw);
    return aw + 2;
  endfunction
endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// dpram_fifo_ctrl_if: write/read handshakes and status of the FIFO controller
interface dpram_fifo_ctrl_if #(parameter int DATA_WIDTH = 16, parameter int ADDRESS_WIDTH = 5);
  import dpram_fifo_ctrl_pkg::*;
  localparam int LW = level_width(ADDRESS_WIDTH);
  logic s_valid, s_ready, m_valid, m_ready, full, empty;
  logic [DATA_WIDTH-1:0] s_data, m_data;
  logic [LW-1:0] level;
  modport master(output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, level, full, empty);
  modport slave(input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, level, full, empty);
endinterface

// File: rtl/dpram_fifo_ctrl_dpram.sv
// dpram: simple dual-port RAM, write on port A, registered 1-cycle read on port B
module dpram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clka,
  input  logic                     wea,
  input  logic [ADDRESS_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0]    dina,
  input  logic                     clkb,
  input  logic                     reb,
  input  logic [ADDRESS_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0]    doutb
);
  import dpram_fifo_ctrl_pkg::*;
  logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDRESS_WIDTH)];
  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dina;
  end
  always_ff @(posedge clkb) begin
    if (reb) doutb <= mem[addrb];
  end
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FIFO over a 1-cycle-latency dpram, read latency hidden by a
// main + skid output stage so one push and one pop per cycle are sustained.
module dpram_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDRESS_WIDTH = 5
) (
  input logic              clk,
  input logic              rst,
  dpram_fifo_ctrl_if.slave bus
);
  import dpram_fifo_ctrl_pkg::*;
  localparam int DEPTH = fifo_depth(ADDRESS_WIDTH);
  localparam int LW = level_width(ADDRESS_WIDTH);
  typedef logic [ADDRESS_WIDTH-1:0] ptr_t;
  typedef logic [ADDRESS_WIDTH:0] cnt_t;
  typedef logic [LW-1:0] lvl_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
  ptr_t wr_ptr, rd_ptr;
  cnt_t ram_cnt, ram_cnt_nxt;
  lvl_t lvl;
  data_t m_data_q, skid_data, doutb;
  logic s_ready_q, s_ready, inflight, m_valid_q, skid_valid, push, pop, issue, main_free;
  assign s_ready = s_ready_q && !rst;
  assign push = bus.s_valid && s_ready;
  assign pop = m_valid_q && bus.m_ready;
  assign main_free = !m_valid_q || pop;
  // Issue only while the returning word is guaranteed a free output-stage slot.
  assign issue = (ram_cnt != '0) && (2'(m_valid_q) + 2'(skid_valid) + 2'(inflight) - 2'(pop) < 2'd2);
  assign ram_cnt_nxt = ram_cnt + cnt_t'(push) - cnt_t'(issue);
  assign lvl = lvl_t'(ram_cnt) + lvl_t'(inflight) + lvl_t'(m_valid_q) + lvl_t'(skid_valid);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ram_cnt <= '0;
      s_ready_q <= 1'b1;
      inflight <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      skid_valid <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ptr_t'(push);
      rd_ptr <= rd_ptr + ptr_t'(issue);
      ram_cnt <= ram_cnt_nxt;
      s_ready_q <= ram_cnt_nxt != FULL_CNT;
      inflight <= issue;
      m_valid_q <= main_free ? skid_valid || inflight : 1'b1;
      m_data_q <= main_free && skid_valid ? skid_data : main_free && inflight ? doutb : m_data_q;
      skid_valid <= main_free ? skid_valid && inflight : skid_valid || inflight;
    end
  end
  always_ff @(posedge clk) begin
    if (inflight && (!main_free || skid_valid)) skid_data <= doutb;
  end
  dpram #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_ram (
    .clka(clk), .wea(push), .addra(wr_ptr), .dina(bus.s_data),
    .clkb(clk), .reb(issue), .addrb(rd_ptr), .doutb(doutb)
  );
  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data = m_data_q;
  assign bus.level = lvl;
  assign bus.full = ram_cnt == FULL_CNT;
  assign bus.empty = lvl == '0;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: directed and random stimulus against a queue reference model
module tb_dpram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  dpram_fifo_ctrl_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(5)) bus();
  dpram_fifo_ctrl #(.DATA_WIDTH(16), .ADDRESS_WIDTH(5)) dut(.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int npop = 0;
  logic [15:0] q[$];
  logic stalled = 1'b0;
  logic [15:0] held = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, judge handshakes before the edge, update model, check after the edge.
  task automatic cycle(input logic sv, input logic [15:0] sd, input logic mr);
    logic pu, po;
    bus.s_valid = sv;
    bus.s_data = sd;
    bus.m_ready = mr;
    #1;
    check("ready_vs_full", bus.s_ready, !bus.full);
    pu = sv && bus.s_ready;
    po = bus.m_valid && mr;
    if (po) begin
      npop++;
      check("pop_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        check("pop_data", bus.m_data, q[0]);
        void'(q.pop_front());
      end
    end
    stalled = bus.m_valid && !mr;
    held = bus.m_data;
    if (pu) q.push_back(sd);
    @(posedge clk);
    #1;
    check("level", bus.level, q.size());
    check("empty", bus.empty, q.size() == 0);
    if (stalled) begin
      check("stall_valid", bus.m_valid, 1);
      check("stall_data", bus.m_data, held);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 16'hdead;
    bus.m_ready = 1'b1;
    #1;
    check("rst_sready", bus.s_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    q.delete();
    stalled = 1'b0;
    #1;
    check("rst_level", bus.level, 0);
    check("rst_mvalid", bus.m_valid, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_sready_after", bus.s_ready, 1);
    check("rst_mdata", bus.m_data, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && q.size() != 0; i++) cycle(1'b0, 16'h0, 1'b1);
    check(tag, bus.empty, 1);
  endtask

  initial begin
    int p10;
    logic [31:0] lvl10;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    do_reset();
    // Latency: push in cycle N shows up in N+3, empty again after the pop.
    repeat (8) cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b1, 16'h0001, 1'b1);
    check("lat_n1", bus.m_valid, 0);
    cycle(1'b0, 16'h0, 1'b1);
    check("lat_n2", bus.m_valid, 0);
    cycle(1'b0, 16'h0, 1'b1);
    check("lat_n3_valid", bus.m_valid, 1);
    check("lat_n3_data", bus.m_data, 16'h0001);
    cycle(1'b0, 16'h0, 1'b1);
    check("lat_n4_empty", bus.empty, 1);
    // Fill: 32 in RAM plus 2 in the output stage.
    do_reset();
    for (int i = 0; i < 34; i++) begin
      check("fill_ready", bus.s_ready, 1);
      cycle(1'b1, 16'(i), 1'b0);
    end
    check("full_flag", bus.full, 1);
    check("full_sready", bus.s_ready, 0);
    check("full_level", bus.level, 34);
    cycle(1'b1, 16'h0022, 1'b0);
    check("full_reject_level", bus.level, 34);
    cycle(1'b0, 16'h0, 1'b1);
    check("refill_ready", bus.s_ready, 1);
    check("refill_notfull", bus.full, 0);
    drain("full_drain");
    // Streaming: one pop per cycle and constant level in steady state.
    do_reset();
    npop = 0;
    p10 = 0;
    lvl10 = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) begin
        p10 = npop;
        lvl10 = bus.level;
      end
      cycle(1'b1, 16'($urandom), 1'b1);
      if (i > 10) check("steady_level", bus.level, lvl10);
    end
    check("steady_pops", npop - p10, 90);
    drain("stream_drain");
    // Toggled m_ready with steady pushes.
    do_reset();
    for (int i = 0; i < 80; i++) cycle(1'b1, 16'($urandom), i % 2 == 0);
    drain("toggle_drain");
    // Mid-operation reset discards held words.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'($urandom), 1'b0);
    check("pre_rst_level", bus.level, 10);
    do_reset();
    cycle(1'b1, 16'hBEEF, 1'b0);
    for (int i = 0; i < 6 && !bus.m_valid; i++) cycle(1'b0, 16'h0, 1'b0);
    check("post_rst_valid", bus.m_valid, 1);
    check("post_rst_first", bus.m_data, 16'hBEEF);
    drain("post_rst_drain");
    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0 && i % 150 < 110);
    drain("random_drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width of the data path and of the internal dpram.
REQ-002 Parameter ADDRESS_WIDTH, default 5: dpram address width; DEPTH = 2**ADDRESS_WIDTH words.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; drives both dpram ports.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 s_valid  input  1  write-side word present.
REQ-007 s_ready  output  1  write side can accept a word.
REQ-008 s_data  input  DATA_WIDTH  write-side word.
REQ-009 m_valid  output  1  read-side word present.
REQ-010 m_ready  input  1  read-side consumer accepts.
REQ-011 m_data  output  DATA_WIDTH  read-side word.
REQ-012 level  output  ADDRESS_WIDTH+2  words held: RAM-resident + in-flight + output stage.
REQ-013 full  output  1  RAM-resident count == DEPTH.
REQ-014 empty  output  1  level == 0.

Function
REQ-015 Push SHALL occur when s_valid && s_ready; it drives wea=1, addra=wr_ptr, dina=s_data in the same cycle; wr_ptr increments modulo DEPTH.
REQ-016 s_ready SHALL be registered and equal !full, except 0 while rst is high.
REQ-017 Pop SHALL occur when m_valid && m_ready; m_data/m_valid SHALL be stable while m_valid && !m_ready.
REQ-018 Read issue: reb=1, addrb=rd_ptr when RAM-resident count > 0 and (output-stage occupancy + in-flight − pop this cycle) < 2; rd_ptr increments modulo DEPTH.
REQ-019 The dpram 1-cycle read latency SHALL be absorbed by a 2-entry output stage (main + skid register); returned data SHALL never be dropped.
REQ-020 Latency: a word pushed in cycle N into an empty block SHALL appear with m_valid=1 in cycle N+3.
REQ-021 Throughput: with s_valid=1 and m_ready=1 continuously and the block non-empty, SHALL sustain one push and one pop per cycle.
REQ-022 Simultaneous push and read issue SHALL be legal; a read SHALL never target an address not yet written, nor a push overwrite an unread address.
REQ-023 RAM-resident count: +1 per push, −1 per read issue, both in the same cycle → unchanged; it never exceeds DEPTH nor goes below 0.
REQ-024 level SHALL update the cycle after each push/pop; push and pop in the same cycle leave it unchanged.
REQ-025 Pointer wrap from DEPTH−1 to 0 SHALL be seamless on both sides.
REQ-026 Data order SHALL be strictly first-in first-out.

Reset
REQ-027 While rst=1: wr_ptr=0, rd_ptr=0, counts=0, output stage empty, m_valid=0, s_ready=0, full=0, empty=1, level=0, m_data=0.
REQ-028 Reset mid-operation SHALL discard all held and in-flight words; RAM contents need not be cleared.
REQ-029 s_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-030 DEPTH and level-width derivations SHALL live in the shared package/include used by dpram users.
REQ-031 Exactly one sub-module: an instance of dpram (DATA_WIDTH, ADDRESS_WIDTH passed through), clka=clkb=clk.
REQ-032 No other storage than the dpram and the 2-entry output stage.

Verification
REQ-033 Push 0x0001 at cycle 10, m_ready=1 → m_valid=1, m_data=0x0001 at cycle 13; empty=1 from cycle 14.
REQ-034 Defaults, m_ready=0, push 0x0000..0x0021 (34 words) continuously → full=1 after 32 RAM-resident (level=34 including output stage), s_ready=0; words beyond are not accepted.
REQ-035 From full, m_ready=1 → pops return 0x0000, 0x0001, ... in order; s_ready returns to 1 one cycle after first read issue.
REQ-036 Continuous push + pop over 100 words (wrap ×3) → one pop per cycle in steady state, level constant, no gaps or reorder.
REQ-037 m_ready toggled 1/0 every cycle with steady pushes → no word lost/duplicated, m_data stable while stalled.
REQ-038 Assert rst for 1 cycle with level=10 → next cycle level=0, m_valid=0, empty=1, s_ready=1; a subsequent push 0xBEEF is the first word popped.
